// File: rtl/motion_box_overlay.sv
// motion_box_overlay: accumulates a per-frame bounding box of motion pixels and overlays it on the video.
// Optional MOTION_MASK_EN paints non-border motion pixels green.
module motion_box_overlay #(
  parameter int          H_DISP     = 640,
  parameter int          V_DISP     = 480,
  parameter int          MIN_PIXELS = 16,
  parameter int          LINE_W     = 2,
  parameter logic [23:0] BOX_COLOR  = 24'hFF0000
) (
  input  logic        pixel_clk,
  input  logic        sys_rst,
  input  logic        data_req,
  input  logic [10:0] pixel_xpos,
  input  logic [10:0] pixel_ypos,
  input  logic [23:0] cam_pixel,
  input  logic        diff_flag,
  output logic [23:0] pixel_data,
  output logic [10:0] box_xmin,
  output logic [10:0] box_xmax,
  output logic [10:0] box_ymin,
  output logic [10:0] box_ymax,
  output logic        box_valid
);
  typedef enum logic [1:0] {IDLE, ACCUM, LATCH} state_t;
  state_t state, state_nx;
  logic first, last, start, acc_en, hit, do_latch, in_box, edge_px;
  logic [10:0] acc_xmin, acc_xmax, acc_ymin, acc_ymax;
  logic [10:0] bxmin, bxmax, bymin, bymax, nxmin, nxmax, nymin, nymax;
  logic [18:0] count, bcnt, ncnt;
  logic [11:0] x, y, bx0, bx1, by0, by1;
  logic [23:0] fill;
  assign first = data_req && pixel_xpos == 11'd1 && pixel_ypos == 11'd1;
  assign last  = data_req && pixel_xpos == 11'(H_DISP) && pixel_ypos == 11'(V_DISP);
  always_ff @(posedge pixel_clk or posedge sys_rst)
    if (sys_rst) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == LATCH ? IDLE :
               state == ACCUM ? (last && !first ? LATCH : ACCUM) :
               (first ? ACCUM : IDLE);
  // A (1,1) request seeds the accumulators, so restarts inside ACCUM fall out naturally
  always_comb begin
    start    = first && state != LATCH;
    acc_en   = start || state == ACCUM;
    do_latch = state == LATCH;
  end
  always_comb begin
    hit   = acc_en && data_req && diff_flag;
    bxmin = start ? 11'h7FF : acc_xmin;
    bymin = start ? 11'h7FF : acc_ymin;
    bxmax = start ? 11'h000 : acc_xmax;
    bymax = start ? 11'h000 : acc_ymax;
    bcnt  = start ? 19'd0 : count;
    nxmin = hit && pixel_xpos < bxmin ? pixel_xpos : bxmin;
    nymin = hit && pixel_ypos < bymin ? pixel_ypos : bymin;
    nxmax = hit && pixel_xpos > bxmax ? pixel_xpos : bxmax;
    nymax = hit && pixel_ypos > bymax ? pixel_ypos : bymax;
    ncnt  = hit && !(&bcnt) ? bcnt + 19'd1 : bcnt;
  end
  always_ff @(posedge pixel_clk or posedge sys_rst)
    if (sys_rst) begin
      acc_xmin <= 11'h7FF;
      acc_ymin <= 11'h7FF;
      acc_xmax <= '0;
      acc_ymax <= '0;
      count    <= '0;
    end else if (acc_en) begin
      acc_xmin <= nxmin;
      acc_ymin <= nymin;
      acc_xmax <= nxmax;
      acc_ymax <= nymax;
      count    <= ncnt;
    end
  always_ff @(posedge pixel_clk or posedge sys_rst)
    if (sys_rst) begin
      box_xmin  <= '0;
      box_xmax  <= '0;
      box_ymin  <= '0;
      box_ymax  <= '0;
      box_valid <= 1'b0;
    end else if (do_latch) begin
      box_valid <= count >= 19'(MIN_PIXELS);
      if (count >= 19'(MIN_PIXELS)) begin
        box_xmin <= acc_xmin;
        box_xmax <= acc_xmax;
        box_ymin <= acc_ymin;
        box_ymax <= acc_ymax;
      end
    end
  // Adding LINE_W to the pixel instead of subtracting it from the max keeps the compare wrap-free
  always_comb begin
    x       = {1'b0, pixel_xpos};
    y       = {1'b0, pixel_ypos};
    bx0     = {1'b0, box_xmin};
    bx1     = {1'b0, box_xmax};
    by0     = {1'b0, box_ymin};
    by1     = {1'b0, box_ymax};
    in_box  = box_valid && x >= bx0 && x <= bx1 && y >= by0 && y <= by1;
    edge_px = x < bx0 + 12'(LINE_W) || x + 12'(LINE_W) > bx1 ||
              y < by0 + 12'(LINE_W) || y + 12'(LINE_W) > by1;
  end
`ifdef MOTION_MASK_EN
  assign fill = diff_flag ? 24'h00FF00 : cam_pixel;
`else
  assign fill = cam_pixel;
`endif
  always_ff @(posedge pixel_clk or posedge sys_rst)
    if (sys_rst) pixel_data <= '0;
    else pixel_data <= !data_req ? 24'h0 : in_box && edge_px ? BOX_COLOR : fill;
endmodule

// File: tb/tb_motion_box_overlay.sv
// tb_motion_box_overlay: randomized frames on a reduced raster checked against a frame-level reference model.
module tb_motion_box_overlay;
  localparam int H = 40, V = 30, MINP = 16, LW = 2, BLANK = 4;
  localparam logic [23:0] BOXC = 24'hFF0000;
  logic clk = 0, rst = 1, data_req = 0, diff_flag = 0;
  logic [10:0] xpos = 0, ypos = 0, box_xmin, box_xmax, box_ymin, box_ymax;
  logic [23:0] cam = 0, pixel_data;
  logic box_valid;
  int checks = 0, errors = 0;
  bit mot [1:V][1:H];
  int m_valid = 0, m_xmin = 0, m_xmax = 0, m_ymin = 0, m_ymax = 0;

  motion_box_overlay #(.H_DISP(H), .V_DISP(V), .MIN_PIXELS(MINP), .LINE_W(LW), .BOX_COLOR(BOXC)) dut (
    .pixel_clk(clk), .sys_rst(rst), .data_req(data_req), .pixel_xpos(xpos), .pixel_ypos(ypos),
    .cam_pixel(cam), .diff_flag(diff_flag), .pixel_data(pixel_data), .box_xmin(box_xmin),
    .box_xmax(box_xmax), .box_ymin(box_ymin), .box_ymax(box_ymax), .box_valid(box_valid));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] ref_pix(input bit req, input int x, input int y, input logic [23:0] c, input bit d);
    bit border;
    if (!req) return 24'h0;
    border = m_valid == 1 && x >= m_xmin && x <= m_xmax && y >= m_ymin && y <= m_ymax &&
             (x - m_xmin < LW || m_xmax - x < LW || y - m_ymin < LW || m_ymax - y < LW);
    if (border) return BOXC;
`ifdef MOTION_MASK_EN
    if (d) return 24'h00FF00;
`endif
    return c;
  endfunction

  task automatic tick(input bit req, input int x, input int y, input logic [23:0] c);
    logic [23:0] e;
    bit d;
    d = req ? mot[y][x] : 1'b0;
    data_req = req; xpos = 11'(x); ypos = 11'(y); cam = c; diff_flag = d;
    e = ref_pix(req, x, y, c, d);
    @(posedge clk); #1;
    chk(req ? "pix" : "blank", 32'(pixel_data), 32'(e));
    @(negedge clk);
  endtask

  task automatic fill(input int x0, input int x1, input int y0, input int y1, input int scatter);
    for (int y = 1; y <= V; y++) for (int x = 1; x <= H; x++)
      mot[y][x] = (x >= x0 && x <= x1 && y >= y0 && y <= y1);
    for (int i = 0; i < scatter; i++) mot[$urandom_range(V, 1)][$urandom_range(H, 1)] = 1;
  endtask

  task automatic frame(input int lines);
    int n, xl, xh, yl, yh;
    for (int y = 1; y <= lines; y++) begin
      for (int x = 1; x <= H; x++) tick(1, x, y, 24'($urandom));
      for (int b = 0; b < BLANK; b++) tick(0, 1, 1, 24'($urandom));
    end
    if (lines != V) return;
    n = 0; xl = 2047; xh = 0; yl = 2047; yh = 0;
    for (int y = 1; y <= V; y++) for (int x = 1; x <= H; x++) if (mot[y][x]) begin
      n++;
      if (x < xl) xl = x;
      if (x > xh) xh = x;
      if (y < yl) yl = y;
      if (y > yh) yh = y;
    end
    m_valid = n >= MINP;
    if (m_valid == 1) begin m_xmin = xl; m_xmax = xh; m_ymin = yl; m_ymax = yh; end
    chk("box_valid", 32'(box_valid), 32'(m_valid));
    chk("box_xmin", 32'(box_xmin), 32'(m_xmin));
    chk("box_xmax", 32'(box_xmax), 32'(m_xmax));
    chk("box_ymin", 32'(box_ymin), 32'(m_ymin));
    chk("box_ymax", 32'(box_ymax), 32'(m_ymax));
  endtask

  initial begin
    fill(0, -1, 0, -1, 0);
    repeat (3) @(negedge clk);
    chk("rst_pix", 32'(pixel_data), 0);
    chk("rst_valid", 32'(box_valid), 0);
    chk("rst_box", {box_xmin, box_xmax[9:0], box_ymin[10:0]}, 0);
    rst = 0;
    @(negedge clk);
    tick(1, 5, 5, 24'h123456);
    tick(0, 1, 1, 24'h0);
    fill(10, 30, 5, 20, 0);
    frame(V);
    chk("dir_xmin", 32'(box_xmin), 10);
    chk("dir_ymax", 32'(box_ymax), 20);
    fill(5, 19, 9, 9, 0);
    frame(V);
    chk("few_valid", 32'(box_valid), 0);
    chk("few_hold", 32'(box_xmax), 30);
    fill(0, -1, 0, -1, 0);
    frame(V);
    fill(7, 7, 3, 18, 0);
    frame(V);
    fill(0, -1, 0, -1, 0);
    frame(V);
    fill(1, 5, 1, 5, 0);
    frame(20);
    fill(20, 35, 10, 25, 0);
    frame(V);
    chk("restart_xmin", 32'(box_xmin), 20);
    fill(2, 38, 2, 28, 0);
    frame(V / 2);
    #2 rst = 1;
    #1;
    chk("arst_pix", 32'(pixel_data), 0);
    chk("arst_valid", 32'(box_valid), 0);
    chk("arst_xmax", 32'(box_xmax), 0);
    m_valid = 0; m_xmin = 0; m_xmax = 0; m_ymin = 0; m_ymax = 0;
    data_req = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    fill(3, 12, 22, 29, 0);
    frame(V);
    chk("post_rst_ymin", 32'(box_ymin), 22);
    for (int i = 0; i < 4; i++) begin
      int a, b, c, d;
      a = $urandom_range(H, 1); b = $urandom_range(H, a);
      c = $urandom_range(V, 1); d = $urandom_range(V, c);
      fill(a, b, c, d, $urandom_range(20, 0));
      frame(V);
    end
    fill(0, -1, 0, -1, 0);
    frame(V);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/motion_box_overlay.md
MOTION_BOX_OVERLAY -- requirements
Module: motion_box_overlay

Interface
REQ-001 SHALL have parameter H_DISP, default 640: active pixels per line.
REQ-002 SHALL have parameter V_DISP, default 480: active lines per frame.
REQ-003 SHALL have parameter MIN_PIXELS, default 16: minimum motion-pixel count per frame for a valid box.
REQ-004 SHALL have parameter LINE_W, default 2: box border thickness in pixels.
REQ-005 SHALL have parameter BOX_COLOR, default 24'hFF0000: RGB888 border colour.
REQ-006 SHALL have port pixel_clk, input, 1: single clock; all logic on its rising edge.
REQ-007 SHALL have port sys_rst, input, 1: reset, asynchronous, active-high.
REQ-008 SHALL have port data_req, input, 1: display driver requests the pixel for the next cycle.
REQ-009 SHALL have port pixel_xpos, input, 11: requested column, 1..H_DISP while data_req=1.
REQ-010 SHALL have port pixel_ypos, input, 11: requested line, 1..V_DISP while data_req=1.
REQ-011 SHALL have port cam_pixel, input, 24: current-frame RGB888, aligned with data_req.
REQ-012 SHALL have port diff_flag, input, 1: frame-difference motion flag, aligned with cam_pixel.
REQ-013 SHALL have port pixel_data, output, 24: RGB888 to the display driver.
REQ-014 SHALL have ports box_xmin, box_xmax, box_ymin, box_ymax, output, 11 each: last latched box.
REQ-015 SHALL have port box_valid, output, 1: latched box is meaningful.

Function
REQ-016 SHALL register pixel_data with latency exactly 1 cycle from the data_req/xpos/ypos/cam_pixel sample; pixel_data=0 the cycle after data_req=0.
REQ-017 SHALL implement FSM IDLE, ACCUM, LATCH; IDLE->ACCUM on data_req at (1,1); ACCUM->LATCH the cycle after data_req at (H_DISP,V_DISP); LATCH->IDLE unconditionally after 1 cycle.
REQ-018 SHALL, on entry to ACCUM, initialise acc_xmin=acc_ymin=11'h7FF, acc_xmax=acc_ymax=0, count=0, counting the (1,1) pixel itself.
REQ-019 SHALL, in ACCUM, for each data_req with diff_flag=1, update min/max with xpos/ypos and increment a 19-bit count (saturating at all-ones).
REQ-020 SHALL, if data_req at (1,1) occurs while in ACCUM (truncated frame), reinitialise accumulators and stay in ACCUM without latching.
REQ-021 SHALL, in LATCH, copy accumulators to box_* and set box_valid=1 if count>=MIN_PIXELS, else leave box_* unchanged and set box_valid=0.
REQ-022 SHALL change box_* / box_valid only in LATCH, so frame N+1 is drawn with frame N's box (no tearing).
REQ-023 SHALL treat a pixel as border when box_valid=1, xmin<=x<=xmax, ymin<=y<=ymax, and (x<xmin+LINE_W or x>xmax-LINE_W or y<ymin+LINE_W or y>ymax-LINE_W), with 12-bit comparisons (no wrap).
REQ-024 SHALL output BOX_COLOR for border pixels, else cam_pixel (subject to REQ-029).
REQ-025 SHALL draw a box narrower than 2*LINE_W as fully filled; single-pixel box (xmin=xmax, ymin=ymax) SHALL colour that one pixel.

Reset
REQ-026 SHALL, on sys_rst=1, asynchronously force FSM=IDLE, pixel_data=0, box_valid=0, box_xmin=box_xmax=box_ymin=box_ymax=0, accumulators to REQ-018 init values.
REQ-027 SHALL discard any partial-frame statistics on reset mid-frame; the first box after reset comes from the first complete frame.

Configuration
REQ-028 SHALL provide macro MOTION_MASK_EN.
REQ-029 SHALL, when MOTION_MASK_EN is defined, output 24'h00FF00 for non-border pixels with diff_flag=1; border colour has priority.
REQ-030 SHALL, when MOTION_MASK_EN is undefined, pass cam_pixel for all non-border pixels, and diff_flag SHALL affect only statistics.

Verification
REQ-031 SHALL test: frame with diff_flag=1 at (100,50)..(200,150), 10201 pixels -> after LATCH box=(100,200,50,150), box_valid=1; next frame (100,80)=(101,80)=24'hFF0000, (102,80)=cam_pixel.
REQ-032 SHALL test: frame with 15 motion pixels -> box_valid=0, box_* hold previous values, next frame all pixels = cam_pixel.
REQ-033 SHALL test: data_req=1 at (5,5), cam_pixel=24'h123456, no box -> pixel_data=24'h123456 exactly one cycle later, 0 the cycle after data_req falls.
REQ-034 SHALL test: sys_rst pulsed mid-frame at line 240 -> outputs 0 immediately (asynchronous), partial-frame stats dropped, next full frame latches normally.
REQ-035 SHALL test: frame restarted at (1,1) after line 300 -> no LATCH, stats only from the restarted frame.
REQ-036 SHALL test, with MOTION_MASK_EN: diff_flag=1 inside box interior -> 24'h00FF00; on border -> 24'hFF0000.
